// File: rtl/oneshot_gen_wb_pkg.sv
// oneshot_gen_wb shared definitions:
// register offsets, CTRL bit layout, frame engine states.
package oneshot_pkg;

  localparam logic [7:0] OFS_WIDTH_BASE = 8'h00;
  localparam logic [7:0] OFS_CTRL       = 8'h40;
  localparam logic [7:0] OFS_PERIOD     = 8'h44;
  localparam logic [7:0] OFS_STATUS     = 8'h48;
  localparam logic [7:0] OFS_ARM        = 8'h4C;

  localparam int CTRL_CONT_BIT = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [31:0] sel_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = sel[b] ? new_v[8*b +: 8]
                           : old_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/oneshot_gen_wb_if.sv
// Wishbone-classic bus bundle between the CPU
// interconnect and the oneshot pulse generator.
interface oneshot_gen_wb_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]   wbm_adr_i;
  logic [DATA_WIDTH-1:0]   wbm_dat_i;
  logic [DATA_WIDTH-1:0]   wbm_dat_o;
  logic                    wbm_we_i;
  logic [SELECT_WIDTH-1:0] wbm_sel_i;
  logic                    wbm_stb_i;
  logic                    wbm_ack_o;
  logic                    wbm_err_o;
  logic                    wbm_rty_o;
  logic                    wbm_cyc_i;

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_we_i,
    output wbm_sel_i, wbm_stb_i, wbm_cyc_i,
    input  wbm_dat_o, wbm_ack_o,
    input  wbm_err_o, wbm_rty_o
  );

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_we_i,
    input  wbm_sel_i, wbm_stb_i, wbm_cyc_i,
    output wbm_dat_o, wbm_ack_o,
    output wbm_err_o, wbm_rty_o
  );
endinterface

// File: rtl/oneshot_gen_wb_channel.sv
// One pulse channel: frame-latched width and enable,
// comparator against the shared frame counter.
module oneshot_channel #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_run,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_width,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pulse
);

  logic [CNT_W-1:0] r_w;
  logic             r_en_sh;
  logic             r_pulse;

  // en only joins at a frame start, but drops out at once
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_w     <= '0;
      r_en_sh <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      if (i_load) begin
        r_w     <= i_width;
        r_en_sh <= i_en;
      end else begin
        r_en_sh <= r_en_sh & i_en;
      end
      r_pulse <= i_run & i_en & r_en_sh
               & (i_cnt < r_w);
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/oneshot_gen_wb.sv
// N-channel oneshot/PWM pulse generator with a
// Wishbone-classic register file and frame engine.
module oneshot_gen_wb
  import oneshot_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int          NUM_CH         = 6,
  parameter int          CNT_W          = 16,
  parameter logic [15:0] DEFAULT_PERIOD = 16'd1000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  oneshot_gen_wb_if.slave   wb,
  output logic [NUM_CH-1:0] o_pulse
);

  logic                    r_ack;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic [CNT_W-1:0]        r_width [NUM_CH];
  logic [NUM_CH-1:0]       r_en;
  logic                    r_cont;
  logic [CNT_W-1:0]        r_period;

  state_t                  r_state, w_state_n;
  logic [CNT_W-1:0]        r_cnt, w_cnt_n;
  logic [CNT_W-1:0]        r_per_sh, w_per_n;
  logic [CNT_W-1:0]        w_p;
  logic [15:0]             r_frames, w_frames_n;
  logic                    w_load, w_last;

  logic [ADDR_WIDTH-1:0]   w_adr;
  logic [SELECT_WIDTH-1:0] w_sel;
  logic [7:0]              w_ofs;
  logic [3:0]              w_ch;
  logic                    w_req, w_wr, w_rd;
  logic                    w_is_width, w_arm;
  logic [CNT_W-1:0]        w_width_sel;
  logic [DATA_WIDTH-1:0]   w_rdata, w_merged;
  logic [DATA_WIDTH-1:0]   w_ctrl, w_status;
  logic                    w_unused;

  assign w_adr  = wb.wbm_adr_i;
  assign w_sel  = wb.wbm_sel_i;
  assign w_ofs  = {w_adr[7:2], 2'b00};
  assign w_ch   = w_adr[5:2];
  assign w_unused = &{1'b0, w_adr[ADDR_WIDTH-1:8],
                      w_adr[1:0]};

  assign w_req = wb.wbm_stb_i & wb.wbm_cyc_i & ~r_ack;
  assign w_wr  = w_req & wb.wbm_we_i;
  assign w_rd  = w_req & ~wb.wbm_we_i;

  assign w_is_width = (w_adr[7:6] == 2'b00)
                    && (int'(w_ch) < NUM_CH);
  assign w_arm = w_wr & (w_ofs == OFS_ARM)
               & w_sel[0] & wb.wbm_dat_i[0];

  always_comb begin
    w_width_sel = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_ch == 4'(n)) w_width_sel = r_width[n];
    end
  end

  assign w_ctrl = 32'(r_en)
                | (32'(r_cont) << CTRL_CONT_BIT);
  assign w_status = {r_frames, 15'd0,
                     r_state == ST_RUN};

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_is_width:             w_rdata = 32'(w_width_sel);
      (w_ofs == OFS_CTRL):    w_rdata = w_ctrl;
      (w_ofs == OFS_PERIOD):  w_rdata = 32'(r_period);
      (w_ofs == OFS_STATUS):  w_rdata = w_status;
      default:                w_rdata = '0;
    endcase
  end

  assign w_merged = sel_merge(w_rdata, wb.wbm_dat_i, w_sel);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_en     <= '0;
      r_cont   <= 1'b0;
      r_period <= CNT_W'(DEFAULT_PERIOD);
      for (int n = 0; n < NUM_CH; n++) r_width[n] <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : '0;
      if (w_wr) begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (w_is_width && w_ch == 4'(n))
            r_width[n] <= w_merged[CNT_W-1:0];
        end
        if (w_ofs == OFS_CTRL) begin
          r_en   <= w_merged[NUM_CH-1:0];
          r_cont <= w_merged[CTRL_CONT_BIT];
        end
        if (w_ofs == OFS_PERIOD)
          r_period <= w_merged[CNT_W-1:0];
      end
    end
  end

  assign wb.wbm_ack_o = r_ack;
  assign wb.wbm_dat_o = r_dat;
  assign wb.wbm_err_o = 1'b0;
  assign wb.wbm_rty_o = 1'b0;

  // frames shorter than 2 ticks are stretched to 2
  assign w_p = (r_per_sh < CNT_W'(2)) ? CNT_W'(2)
                                      : r_per_sh;
  assign w_last = (r_cnt == w_p - CNT_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_per_sh <= CNT_W'(DEFAULT_PERIOD);
      r_frames <= '0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_per_sh <= w_per_n;
      r_frames <= w_frames_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_frames_n = r_frames;
    w_load     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_cont | w_arm) begin
          w_state_n = ST_RUN;
          w_cnt_n   = '0;
          w_load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_frames_n = r_frames + 16'd1;
          if (r_cont) begin
            w_cnt_n = '0;
            w_load  = 1'b1;
          end else begin
            w_state_n = ST_IDLE;
          end
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
    w_per_n = w_load ? r_period : r_per_sh;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    oneshot_channel #(.CNT_W(CNT_W)) u_ch (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_load),
      .i_run   (r_state == ST_RUN),
      .i_en    (r_en[g]),
      .i_width (r_width[g]),
      .i_cnt   (r_cnt),
      .o_pulse (o_pulse[g])
    );
  end

endmodule

// File: tb/tb_oneshot_gen_wb.sv
// Directed bench for oneshot_gen_wb: register table
// plus hand-timed frame, one-shot and reset sequences.
module tb_oneshot_gen_wb;

  typedef struct {
    string       name;
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  pulse;
  int          checks = 0;
  int          errors = 0;
  int unsigned hi0 = 0;
  vec_t        tv[$];

  always #5 clk = ~clk;

  oneshot_gen_wb_if wb ();

  oneshot_gen_wb dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .wb      (wb),
    .o_pulse (pulse)
  );

  always @(posedge clk) hi0 <= hi0 + 32'(pulse[0]);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] adr,
                      input logic we,
                      input logic [31:0] dat,
                      input logic [3:0] sel,
                      output logic [31:0] rd);
    int n;
    wb.wbm_adr_i = adr;
    wb.wbm_we_i  = we;
    wb.wbm_dat_i = dat;
    wb.wbm_sel_i = sel;
    wb.wbm_stb_i = 1'b1;
    wb.wbm_cyc_i = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!wb.wbm_ack_o && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_latency", 32'(n), 32'd0);
    chk("err_rty", {30'd0, wb.wbm_err_o, wb.wbm_rty_o}, 0);
    rd = wb.wbm_dat_o;
    wb.wbm_stb_i = 1'b0;
    wb.wbm_cyc_i = 1'b0;
    wb.wbm_we_i  = 1'b0;
    @(posedge clk); #1;
    chk("ack_drop", 32'(wb.wbm_ack_o), 32'd0);
  endtask

  task automatic wr(input logic [31:0] adr,
                    input logic [31:0] dat);
    logic [31:0] d;
    xfer(adr, 1'b1, dat, 4'hF, d);
  endtask

  task automatic rd_chk(input string nm,
                        input logic [31:0] adr,
                        input logic [31:0] exp);
    logic [31:0] d;
    xfer(adr, 1'b0, 32'd0, 4'hF, d);
    chk(nm, d, exp);
  endtask

  task automatic wait_rise();
    logic prev;
    logic found;
    prev  = pulse[0];
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (pulse[0] && !prev) found = 1'b1;
      prev = pulse[0];
    end
    chk("pulse_rise_seen", 32'(found), 32'd1);
  endtask

  function automatic vec_t mk(string nm, logic [31:0] a,
                              logic we, logic [31:0] d,
                              logic [3:0] s, logic [31:0] e);
    vec_t v;
    v.name = nm; v.adr = a; v.we = we;
    v.dat = d; v.sel = s; v.exp = e;
    return v;
  endfunction

  initial begin
    logic [31:0] d, st1, st2;
    int unsigned h;
    int mism;

    tv.push_back(mk("rst_w0",    32'h00, 0, 0, 4'hF, 0));
    tv.push_back(mk("rst_w5",    32'h14, 0, 0, 4'hF, 0));
    tv.push_back(mk("rst_ctrl",  32'h40, 0, 0, 4'hF, 0));
    tv.push_back(mk("rst_per",   32'h44, 0, 0, 4'hF, 1000));
    tv.push_back(mk("rst_stat",  32'h48, 0, 0, 4'hF, 0));
    tv.push_back(mk("arm_rd",    32'h4C, 0, 0, 4'hF, 0));
    tv.push_back(mk("w6_unmap",  32'h18, 0, 0, 4'hF, 0));
    tv.push_back(mk("",  32'h04, 1, 32'h1234, 4'hF, 0));
    tv.push_back(mk("w1_full",   32'h04, 0, 0, 4'hF, 32'h1234));
    tv.push_back(mk("",  32'h04, 1, 32'hAB, 4'h1, 0));
    tv.push_back(mk("w1_byte",   32'h04, 0, 0, 4'hF, 32'h12AB));
    tv.push_back(mk("",  32'h04, 1, 32'hFFFF_FFFF, 4'hC, 0));
    tv.push_back(mk("w1_hi_sel", 32'h04, 0, 0, 4'hF, 32'h12AB));
    tv.push_back(mk("",  32'h80, 1, 32'hDEAD, 4'hF, 0));
    tv.push_back(mk("unmap_rd",  32'h80, 0, 0, 4'hF, 0));
    tv.push_back(mk("",  32'h48, 1, 32'hFFFF, 4'hF, 0));
    tv.push_back(mk("stat_ro",   32'h48, 0, 0, 4'hF, 0));
    tv.push_back(mk("",  32'h44, 1, 32'h12345, 4'hF, 0));
    tv.push_back(mk("per_trunc", 32'h44, 0, 0, 4'hF, 32'h2345));
    tv.push_back(mk("",  32'h40, 1, 32'hFFFF_FFFF, 4'h1, 0));
    tv.push_back(mk("ctrl_en",   32'h40, 0, 0, 4'hF, 32'h3F));
    tv.push_back(mk("",  32'h40, 1, 32'h0, 4'hF, 0));
    tv.push_back(mk("",  32'h04, 1, 32'h0, 4'hF, 0));

    rst = 1'b1;
    wb.wbm_adr_i = '0;
    wb.wbm_dat_i = '0;
    wb.wbm_we_i  = 1'b0;
    wb.wbm_sel_i = '0;
    wb.wbm_stb_i = 1'b0;
    wb.wbm_cyc_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_ack", 32'(wb.wbm_ack_o), 0);
    chk("rst_dat", wb.wbm_dat_o, 0);
    rst = 1'b0;

    foreach (tv[i]) begin
      xfer(tv[i].adr, tv[i].we, tv[i].dat, tv[i].sel, d);
      if (!tv[i].we) chk(tv[i].name, d, tv[i].exp);
    end

    // continuous 3/10 PWM on channel 0
    wr(32'h44, 32'd10);
    wr(32'h00, 32'd3);
    wr(32'h40, 32'h10001);
    wait_rise();
    mism = 0;
    for (int k = 0; k < 30; k++) begin
      if (pulse[0] !== ((k % 10) < 3)) mism++;
      @(posedge clk); #1;
    end
    chk("cont_3_of_10", 32'(mism), 0);
    xfer(32'h48, 1'b0, 0, 4'hF, st1);
    repeat (18) @(posedge clk);
    #1;
    xfer(32'h48, 1'b0, 0, 4'hF, st2);
    chk("cont_busy", 32'(st1[0]), 1);
    chk("frames_per_20", 32'(st2[31:16] - st1[31:16]), 2);
    wr(32'h40, 32'h0);
    repeat (15) @(posedge clk);
    #1;
    rd_chk("cont_off_stat_busy", 32'h48, {st2[31:16] + 16'd1, 16'd0});

    // single armed frame, second ARM ignored
    wr(32'h40, 32'h3F);
    xfer(32'h48, 1'b0, 0, 4'hF, st1);
    h = hi0;
    wr(32'h4C, 32'd1);
    xfer(32'h48, 1'b0, 0, 4'hF, d);
    chk("arm_busy", 32'(d[0]), 1);
    wr(32'h4C, 32'd1);
    xfer(32'h48, 1'b0, 0, 4'hF, d);
    chk("arm2_busy", 32'(d[0]), 1);
    repeat (12) @(posedge clk);
    #1;
    xfer(32'h48, 1'b0, 0, 4'hF, d);
    chk("arm_done_busy", 32'(d[0]), 0);
    chk("arm_one_frame", 32'(d[31:16] - st1[31:16]), 1);
    chk("arm_hi_cycles", hi0 - h, 3);

    // width change mid-frame lands at next frame
    wr(32'h40, 32'h10001);
    wait_rise();
    wr(32'h00, 32'd7);
    chk("mid_still_high", 32'(pulse[0]), 1);
    mism = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      if (pulse[0] !== (k >= 7 && ((k - 7) % 10) < 7))
        mism++;
    end
    chk("mid_w3_then_w7", 32'(mism), 0);

    wr(32'h00, 32'd0);
    repeat (25) @(posedge clk);
    #1;
    h = hi0;
    repeat (20) @(posedge clk);
    #1;
    chk("w0_flat_low", hi0 - h, 0);

    wr(32'h00, 32'd12);
    repeat (25) @(posedge clk);
    #1;
    h = hi0;
    repeat (20) @(posedge clk);
    #1;
    chk("w12_const_high", hi0 - h, 20);

    // reset at cnt=5 with a read in flight
    wr(32'h00, 32'd7);
    repeat (25) @(posedge clk);
    #1;
    wait_rise();
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_high", 32'(pulse[0]), 1);
    wb.wbm_adr_i = 32'h44;
    wb.wbm_we_i  = 1'b0;
    wb.wbm_sel_i = 4'hF;
    wb.wbm_stb_i = 1'b1;
    wb.wbm_cyc_i = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_pulse", 32'(pulse), 0);
    chk("rst_mid_ack", 32'(wb.wbm_ack_o), 0);
    chk("rst_mid_dat", wb.wbm_dat_o, 0);
    wb.wbm_stb_i = 1'b0;
    wb.wbm_cyc_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_no_ack", 32'(wb.wbm_ack_o), 0);
    rd_chk("post_rst_w0", 32'h00, 0);
    rd_chk("post_rst_ctrl", 32'h40, 0);
    rd_chk("post_rst_per", 32'h44, 1000);
    rd_chk("post_rst_stat", 32'h48, 0);
    h = hi0;
    repeat (15) @(posedge clk);
    #1;
    chk("post_rst_low", hi0 - h, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
